sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 4: cycles of track phase per conversion; legal range is 1 or more.
REQ-002 SHALL have parameter SETTLE, default 4: cycles per bit-trial window; legal range is 3 or more, which covers DAC settling plus the 2-flop synchronizer.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: conversion request, level-sampled in IDLE.
REQ-006 SHALL have port cmp, input, 1 bit: asynchronous comparator output, 1 when Vin is at or above Vdac.
REQ-007 SHALL have port hold, output, 1 bit: sample/hold control, 0 = track, 1 = hold.
REQ-008 SHALL have port dac_code, output, 10 bits: trial code to the feedback DAC.
REQ-009 SHALL have port busy, output, 1 bit: 1 in SAMPLE or CONVERT.
REQ-010 SHALL have port data, output, 10 bits: conversion result.
REQ-011 SHALL have port valid, output, 1 bit: data is valid.
REQ-012 SHALL have port ready, input, 1 bit: consumer accepts data.
REQ-013 SHALL have port ovr, output, 1 bit: sticky overrun flag.

Function
REQ-014 SHALL implement FSM states IDLE, SAMPLE, CONVERT and DONE.
REQ-015 SHALL pass cmp through a 2-flop synchronizer to form cmp_s; only cmp_s is used internally.
REQ-016 IDLE: when start=1 at an edge, SHALL go to SAMPLE, clear the result register, and load the SAMPLE_CYCLES counter.
REQ-017 SAMPLE: hold=0, dac_code=0x000, busy=1; after exactly SAMPLE_CYCLES cycles SHALL go to CONVERT with bit index 9.
REQ-018 CONVERT, per bit i from 9 down to 0: for the whole SETTLE-cycle window, dac_code SHALL equal the resolved upper bits OR (1 shifted left by i), with lower bits 0; hold=1.
REQ-019 At the last edge of each bit window, bit i SHALL be kept when cmp_s=1 and cleared when cmp_s=0.
REQ-020 After bit 0 resolves, SHALL register the result into data, set valid=1, and go to DONE.
REQ-021 Latency: with start seen at edge t0, valid SHALL first be 1 after edge t0+SAMPLE_CYCLES+10*SETTLE, which is 44 cycles at defaults.
REQ-022 DONE: valid and data SHALL hold stable until an edge with ready=1; at that edge valid SHALL drop and the FSM SHALL return to IDLE.
REQ-023 If start=1 at that same DONE-exit edge, the next conversion SHALL begin from IDLE on the following edge; no cycle is skipped or merged.
REQ-024 DONE: hold=0 and dac_code=0x000; data SHALL retain the last result after valid drops, until the next REQ-020 update.
REQ-025 start=1 at any edge while in SAMPLE, CONVERT or DONE SHALL be ignored for control and SHALL set ovr=1.
REQ-026 ovr SHALL clear only on reset.
REQ-027 ready SHALL be ignored outside DONE.
REQ-028 The cmp level at the boundary: cmp_s=1 when Vin equals Vdac SHALL keep the trial bit, so full scale resolves to 0x3FF and zero to 0x000.

Reset
REQ-029 reset=1 SHALL immediately, asynchronously, set state=IDLE, hold=0, dac_code=0x000, busy=0, data=0x000, valid=0, ovr=0, and clear the synchronizer, counters and result register.
REQ-030 Reset asserted in any state, including mid-CONVERT or DONE with valid=1, SHALL discard the conversion in progress with no partial data.
REQ-031 After reset deasserts, SHALL stay in IDLE until start=1.

Verification
REQ-032 Bench comparator model: cmp = (VIN_CODE >= dac_code). VIN_CODE=0x2A5, start pulse at t0, ready=1 -> valid=1 first after edge t0+44, data=0x2A5, dac_code sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2A8,0x2A4,0x2A6,0x2A5.
REQ-033 VIN_CODE=0x3FF -> data=0x3FF; VIN_CODE=0x000 -> data=0x000; both with latency 44.
REQ-034 Backpressure: ready=0 for 10 cycles after valid rises, start pulsed during DONE -> valid and data stable, ovr=1, no new conversion; ready=1 -> valid=0, FSM returns to IDLE.
REQ-035 Reset mid-conversion: reset=1 at cycle 20 after start -> all outputs take their REQ-029 values immediately; after release, a new start yields the correct result 44 cycles later.
REQ-036 start held at 1 continuously with ready=1 -> back-to-back conversions, one valid per 46 cycles (IDLE + 44 + DONE), ovr=1 set during the first conversion.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: tracks the input, resolves a 10-bit code
// MSB-first against a synchronized comparator, then offers the result with ready/valid.
module sar_adc_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE        = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       cmp,
  output logic       hold,
  output logic [9:0] dac_code,
  output logic       busy,
  output logic [9:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       ovr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAMPLE  = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE) ? SAMPLE_CYCLES : SETTLE;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    result_q, result_d;
  logic [9:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic [1:0]    sync_q;
  logic          cmp_s;
  logic [9:0]    trial_bit;

  assign cmp_s     = sync_q[1];
  assign trial_bit = 10'd1 << bit_idx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    result_d  = result_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (start && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SAMPLE;
          result_d = 10'd0;
          cnt_d    = CW'(SAMPLE_CYCLES - 1);
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d   = CONVERT;
          bit_idx_d = 4'd9;
          cnt_d     = CW'(SETTLE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_q == '0) begin
          // The trial bit survives only when the comparator says Vin >= Vdac.
          result_d = cmp_s ? (result_q | trial_bit) : result_q;
          if (bit_idx_q == 4'd0) begin
            state_d = DONE;
            data_d  = cmp_s ? (result_q | trial_bit) : result_q;
            valid_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
            cnt_d     = CW'(SETTLE - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      result_q  <= 10'd0;
      data_q    <= 10'd0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      sync_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      result_q  <= result_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      sync_q    <= {sync_q[0], cmp};
    end
  end

  // Outputs decode straight from state flops so reset reaches them without a clock.
  assign hold     = (state_q == CONVERT);
  assign busy     = (state_q == SAMPLE) || (state_q == CONVERT);
  assign dac_code = (state_q == CONVERT) ? (result_q | trial_bit) : 10'd0;
  assign data     = data_q;
  assign valid    = valid_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator cmp = (vin_code >= dac_code).
module tb_sar_adc_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic       cmp;
  logic       hold;
  logic [9:0] dac_code;
  logic       busy;
  logic [9:0] data;
  logic       valid;
  logic       ovr;
  logic [9:0] vin_code = 10'd0;

  int tests = 0;
  int fails = 0;

  logic [9:0] seq_2a5 [10] = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                               10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};

  always #5 CLK = ~CLK;

  assign cmp = (vin_code >= dac_code);

  sar_adc_ctrl dut (
    .CLK(CLK), .reset(reset), .start(start), .cmp(cmp), .hold(hold),
    .dac_code(dac_code), .busy(busy), .data(data), .valid(valid),
    .ready(ready), .ovr(ovr)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One conversion from a single-cycle start pulse; returns just after edge t0+44.
  task automatic run_conv(input logic [9:0] vin, input logic [9:0] expd, input bit chk_seq);
    vin_code = vin;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      step();
      if (k == 2) begin
        chk("sample_busy", busy, 1);
        chk("sample_hold", hold, 0);
        chk("sample_dac", dac_code, 0);
      end
      if (k == 10) chk("convert_hold", hold, 1);
      if (chk_seq && k >= 7 && k <= 43 && ((k - 7) % 4 == 0))
        chk($sformatf("dac_bit%0d", 9 - (k - 7) / 4), dac_code, seq_2a5[(k - 7) / 4]);
      if (k == 43) chk("valid_t43", valid, 0);
    end
    chk("valid_t44", valid, 1);
    chk($sformatf("data_%h", vin), data, expd);
    $display("[TB] conversion vin=%h data=%h valid=%0d", vin, data, valid);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_data", data, 0);
    chk("rst_ovr", ovr, 0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("idle_busy", busy, 0);

    // Normal conversion, DONE exits on the next edge since ready=1
    ready = 1'b1;
    run_conv(10'h2A5, 10'h2A5, 1'b1);
    step();
    chk("done_exit_valid", valid, 0);
    chk("data_retained", data, 10'h2A5);
    chk("done_dac", dac_code, 0);
    step();
    chk("idle_after_done", busy, 0);

    run_conv(10'h3FF, 10'h3FF, 1'b0);
    step();
    run_conv(10'h000, 10'h000, 1'b0);
    step();
    chk("no_ovr_yet", ovr, 0);

    // Backpressure with a start pulse during DONE
    ready = 1'b0;
    run_conv(10'h155, 10'h155, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      start = (c == 3);
      step();
      start = 1'b0;
      if (c == 2 || c == 6 || c == 10) begin
        chk("bp_valid", valid, 1);
        chk("bp_data", data, 10'h155);
        chk("bp_busy", busy, 0);
        chk("bp_hold", hold, 0);
      end
      if (c == 4) chk("bp_ovr", ovr, 1);
    end
    $display("[TB] backpressure valid=%0d ovr=%0d", valid, ovr);
    ready = 1'b1;
    step();
    chk("bp_release_valid", valid, 0);
    step();
    chk("bp_no_new_conv", busy, 0);
    chk("bp_ovr_sticky", ovr, 1);

    // Reset 20 cycles into a conversion
    vin_code = 10'h0F0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", hold, 0);
    chk("mid_rst_dac", dac_code, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ovr", ovr, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("post_rst_idle", busy, 0);
    run_conv(10'h0F0, 10'h0F0, 1'b0);
    step();
    $display("[TB] reset recovery data=%h", data);

    // start held high: back-to-back conversions every 46 cycles
    vin_code = 10'h1A3;
    ready = 1'b1;
    start = 1'b1;
    step();
    for (int k = 1; k <= 90; k++) begin
      step();
      if (k == 2) chk("b2b_ovr", ovr, 1);
      if (k == 43 || k == 45 || k == 89) chk($sformatf("b2b_valid_t%0d", k), valid, 0);
      if (k == 44 || k == 90) begin
        chk($sformatf("b2b_valid_t%0d", k), valid, 1);
        chk($sformatf("b2b_data_t%0d", k), data, 10'h1A3);
        $display("[TB] back-to-back t0+%0d data=%h", k, data);
      end
    end
    start = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
